// File: rtl/ir_pkg.sv
// Shared definitions for the IR command scheduler: the FSM state type,
// the command nibble width and the register offsets from IO_ADDRESS.
package ir_pkg;

  localparam int CMD_W = 4;

  // Register offsets relative to IO_ADDRESS
  localparam logic [7:0] REG_PUSH = 8'd0;
  localparam logic [7:0] REG_CTRL = 8'd1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_DONE = 2'd2
  } ir_state_t;

endpackage

// File: rtl/ir_cmd_fifo.sv
// Command queue for the IR scheduler: DEPTH entries of CMD_W bits, with
// push, pop and flush, plus a sticky overflow flag for dropped pushes.
// DEPTH must be a power of two so the pointers wrap naturally.
module ir_cmd_fifo
  import ir_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [CMD_W-1:0]         i_din,
  output logic [CMD_W-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;
  logic w_drop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // A flush wins over everything; a push into a full queue is only
  // accepted when a pop frees the head slot in the same cycle.
  assign w_do_pop  = i_pop && !w_empty && !i_flush;
  assign w_do_push = i_push && !i_flush && (!w_full || w_do_pop);
  assign w_drop    = i_push && !i_flush && w_full && !w_do_pop;

  // Storage write; contents need no reset because occupancy gates reads
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers, occupancy and sticky overflow
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_head     = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/ir_command_scheduler.sv
// IR command scheduler: queues command nibbles written over the bus and
// hands one to the IR transmitter per send slot using a request/busy
// handshake. Optional macro IR_REPEAT_LAST_EN re-sends the last command
// on a slot where the queue is empty.
module ir_command_scheduler
  import ir_pkg::*;
#(
  parameter logic [7:0] IO_ADDRESS  = 8'h90,
  parameter int         FIFO_DEPTH  = 4,
  parameter int         TICK_CYCLES = 10_000_000
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          BUS_WE,
  input  logic [7:0]                    BUS_ADDR,
  input  logic [7:0]                    BUS_DATA,
  input  logic                          TX_BUSY,
  output logic [3:0]                    COMMAND,
  output logic                          SEND_PACKET,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
  output logic                          FIFO_FULL,
  output logic                          OVERFLOW
);

  localparam int               TICK_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [7:0]       PUSH_ADDR = IO_ADDRESS + REG_PUSH;
  localparam logic [7:0]       CTRL_ADDR = IO_ADDRESS + REG_CTRL;

  logic [TICK_W-1:0] r_tick_cnt;
  ir_state_t         r_state;
  ir_state_t         w_state_next;
  logic [CMD_W-1:0]  r_command;

  logic             w_tick;
  logic             w_push;
  logic             w_flush;
  logic             w_pop;
  logic             w_empty;
  logic [CMD_W-1:0] w_head;
  logic             w_unused_data;

  assign w_push        = BUS_WE && (BUS_ADDR == PUSH_ADDR);
  assign w_flush       = BUS_WE && (BUS_ADDR == CTRL_ADDR) && BUS_DATA[0];
  assign w_tick        = (r_tick_cnt == TICK_LAST);
  assign w_unused_data = ^BUS_DATA[7:4];

  ir_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (CLK),
    .i_rst_n    (RESET),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_flush    (w_flush),
    .i_din      (BUS_DATA[CMD_W-1:0]),
    .o_head     (w_head),
    .o_count    (FIFO_COUNT),
    .o_full     (FIFO_FULL),
    .o_empty    (w_empty),
    .o_overflow (OVERFLOW)
  );

  // Free-running send-slot counter, independent of the handshake
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

`ifdef IR_REPEAT_LAST_EN
  logic r_last_valid;

  // Remembers that COMMAND holds something worth re-sending
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_last_valid <= 1'b0;
    end else if (w_pop) begin
      r_last_valid <= 1'b1;
    end
  end
`endif

  // Handshake state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and pop decision; ticks outside IDLE are simply dropped
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_tick) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_state_next = ST_REQ;
          end
`ifdef IR_REPEAT_LAST_EN
          else if (r_last_valid) begin
            w_state_next = ST_REQ;
          end
`endif
        end
      end
      ST_REQ: begin
        if (TX_BUSY) begin
          w_state_next = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!TX_BUSY) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // COMMAND is loaded only on a pop, so it stays put through the handshake
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_command <= '0;
    end else if (w_pop) begin
      r_command <= w_head;
    end
  end

  assign COMMAND     = r_command;
  assign SEND_PACKET = (r_state == ST_REQ);

endmodule

// File: tb/tb_ir_command_scheduler.sv
// Self-checking bench for ir_command_scheduler (TICK_CYCLES=16, FIFO_DEPTH=4).
// A queue-based reference model tracks what the outputs should be each cycle.
module tb_ir_command_scheduler;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       BUS_WE = 1'b0;
  logic [7:0] BUS_ADDR = 8'h00;
  logic [7:0] BUS_DATA = 8'h00;
  logic       TX_BUSY = 1'b0;
  logic [3:0] COMMAND;
  logic       SEND_PACKET;
  logic [2:0] FIFO_COUNT;
  logic       FIFO_FULL;
  logic       OVERFLOW;

`ifdef IR_REPEAT_LAST_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  ir_command_scheduler #(
    .IO_ADDRESS  (8'h90),
    .FIFO_DEPTH  (4),
    .TICK_CYCLES (16)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .BUS_WE      (BUS_WE),
    .BUS_ADDR    (BUS_ADDR),
    .BUS_DATA    (BUS_DATA),
    .TX_BUSY     (TX_BUSY),
    .COMMAND     (COMMAND),
    .SEND_PACKET (SEND_PACKET),
    .FIFO_COUNT  (FIFO_COUNT),
    .FIFO_FULL   (FIFO_FULL),
    .OVERFLOW    (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: queue of pending commands, cycles since reset,
  // last sent command and handshake phase (0 idle, 1 requesting, 2 tx busy)
  logic [3:0] m_q[$];
  int         m_e;
  int         m_phase;
  bit         m_sent;
  bit         m_ovf;
  logic [3:0] m_cmd;

  typedef struct {
    bit         we;
    logic [7:0] addr;
    logic [7:0] data;
    bit         busy;
    int         cnt;
    bit         full;
    bit         ovf;
    bit         send;
    int         cmd;
  } vec_t;

  vec_t vt[18];

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_e     = 0;
    m_phase = 0;
    m_sent  = 0;
    m_ovf   = 0;
    m_cmd   = 4'h0;
  endtask

  // One clock edge worth of behaviour, from the current bus/TX inputs
  task automatic model_edge();
    bit tick;
    bit flush;
    bit push;
    tick  = (m_e % 16) == 15;
    m_e++;
    flush = BUS_WE && (BUS_ADDR == 8'h91) && BUS_DATA[0];
    push  = BUS_WE && (BUS_ADDR == 8'h90);
    case (m_phase)
      0: if (tick) begin
        if (m_q.size() > 0) begin
          m_cmd   = m_q.pop_front();
          m_phase = 1;
          m_sent  = 1;
        end else if (REPEAT && m_sent) begin
          m_phase = 1;
        end
      end
      1: if (TX_BUSY) m_phase = 2;
      default: if (!TX_BUSY) m_phase = 0;
    endcase
    if (flush) begin
      m_q.delete();
      m_ovf = 0;
    end else if (push) begin
      if (m_q.size() < 4) m_q.push_back(BUS_DATA[3:0]);
      else m_ovf = 1;
    end
  endtask

  task automatic compare_model(string tag);
    chk({tag, ".cmd"},   COMMAND, m_cmd);
    chk({tag, ".send"},  SEND_PACKET, (m_phase == 1) ? 1 : 0);
    chk({tag, ".count"}, FIFO_COUNT, m_q.size());
    chk({tag, ".full"},  FIFO_FULL, (m_q.size() == 4) ? 1 : 0);
    chk({tag, ".ovf"},   OVERFLOW, m_ovf);
  endtask

  task automatic step(string tag);
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare_model(tag);
  endtask

  task automatic bus(bit we, logic [7:0] addr, logic [7:0] data);
    BUS_WE   = we;
    BUS_ADDR = addr;
    BUS_DATA = data;
  endtask

  // Reset asserted and released on falling edges; outputs checked in reset
  task automatic do_reset(string tag);
    @(negedge CLK);
    RESET   = 1'b0;
    TX_BUSY = 1'b0;
    bus(0, 8'h00, 8'h00);
    model_reset();
    #1;
    chk({tag, ".rst_cmd"},   COMMAND, 0);
    chk({tag, ".rst_send"},  SEND_PACKET, 0);
    chk({tag, ".rst_count"}, FIFO_COUNT, 0);
    chk({tag, ".rst_full"},  FIFO_FULL, 0);
    chk({tag, ".rst_ovf"},   OVERFLOW, 0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic run_to_send(string tag, int limit);
    int k = 0;
    while (m_phase != 1 && k < limit) begin
      step(tag);
      k++;
    end
    chk({tag, ".send_rise"}, SEND_PACKET, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1, 8'h90, 8'h01, 0, 1, 0, 0, 0, 0};
    vt[1]  = '{1, 8'h90, 8'h02, 0, 2, 0, 0, 0, 0};
    vt[2]  = '{1, 8'h90, 8'h13, 0, 3, 0, 0, 0, 0};
    vt[3]  = '{1, 8'h90, 8'h04, 0, 4, 1, 0, 0, 0};
    vt[4]  = '{1, 8'h90, 8'h05, 0, 4, 1, 1, 0, 0};
    vt[5]  = '{0, 8'h00, 8'h00, 0, 4, 1, 1, 0, 0};
    vt[6]  = '{1, 8'h91, 8'h00, 0, 4, 1, 1, 0, 0};
    vt[7]  = '{1, 8'h92, 8'h01, 0, 4, 1, 1, 0, 0};
    vt[8]  = '{1, 8'h91, 8'h01, 0, 0, 0, 0, 0, 0};
    vt[9]  = '{1, 8'h90, 8'h07, 0, 1, 0, 0, 0, 0};
    vt[10] = '{1, 8'h90, 8'h08, 0, 2, 0, 0, 0, 0};
    vt[11] = '{1, 8'h91, 8'hFF, 0, 0, 0, 0, 0, 0};
    vt[12] = '{1, 8'h90, 8'h09, 0, 1, 0, 0, 0, 0};
    vt[13] = '{0, 8'h00, 8'h00, 0, 1, 0, 0, 0, 0};
    vt[14] = '{0, 8'h00, 8'h00, 0, 1, 0, 0, 0, 0};
    vt[15] = '{1, 8'h90, 8'h0B, 0, 1, 0, 0, 1, 9};
    vt[16] = '{0, 8'h00, 8'h00, 1, 1, 0, 0, 0, 9};
    vt[17] = '{0, 8'h00, 8'h00, 0, 1, 0, 0, 0, 9};

    // Table: fill to overflow, flush, then push+pop on the first tick
    do_reset("T");
    for (int i = 0; i < 18; i++) begin
      bus(vt[i].we, vt[i].addr, vt[i].data);
      TX_BUSY = vt[i].busy;
      step("T");
      $display("vec %0d: we=%0d addr=%h data=%h busy=%0d -> count=%0d full=%0d ovf=%0d send=%0d cmd=%h",
               i, vt[i].we, vt[i].addr, vt[i].data, vt[i].busy,
               FIFO_COUNT, FIFO_FULL, OVERFLOW, SEND_PACKET, COMMAND);
      chk($sformatf("T%0d.count", i), FIFO_COUNT, vt[i].cnt);
      chk($sformatf("T%0d.full", i),  FIFO_FULL, vt[i].full);
      chk($sformatf("T%0d.ovf", i),   OVERFLOW, vt[i].ovf);
      chk($sformatf("T%0d.send", i),  SEND_PACKET, vt[i].send);
      chk($sformatf("T%0d.cmd", i),   COMMAND, vt[i].cmd);
    end
    bus(0, 8'h00, 8'h00);

    // Single command handshake, then behaviour on an empty-queue tick
    do_reset("A");
    bus(1, 8'h90, 8'hFA);
    step("A.push");
    bus(0, 8'h00, 8'h00);
    chk("A.count1", FIFO_COUNT, 1);
    run_to_send("A", 40);
    chk("A.cmd", COMMAND, 4'hA);
    chk("A.count0", FIFO_COUNT, 0);
    step("A.hold1");
    step("A.hold2");
    chk("A.send_held", SEND_PACKET, 1);
    TX_BUSY = 1'b1;
    step("A.busy");
    chk("A.send_drop", SEND_PACKET, 0);
    repeat (4) step("A.busy");
    TX_BUSY = 1'b0;
    step("A.done");
    begin
      int k = 0;
      do begin
        step("D");
        k++;
      end while ((m_e % 16) != 0 && k < 20);
    end
    $display("repeat tick: send=%0d cmd=%h", SEND_PACKET, COMMAND);
    chk("D.repeat_send", SEND_PACKET, REPEAT);
    chk("D.cmd", COMMAND, 4'hA);

    // Long busy: ticks during the handshake must not pop
    do_reset("C");
    bus(1, 8'h90, 8'h03); step("C.push");
    bus(1, 8'h90, 8'h05); step("C.push");
    bus(1, 8'h90, 8'h06); step("C.push");
    bus(0, 8'h00, 8'h00);
    run_to_send("C", 40);
    TX_BUSY = 1'b1;
    repeat (40) step("C.busy");
    chk("C.count_hold", FIFO_COUNT, 2);
    chk("C.cmd_hold", COMMAND, 4'h3);
    TX_BUSY = 1'b0;
    step("C.done");
    run_to_send("C2", 40);
    chk("C2.cmd", COMMAND, 4'h5);
    chk("C2.count", FIFO_COUNT, 1);
    $display("long busy: second send cmd=%h count=%0d", COMMAND, FIFO_COUNT);

    // Asynchronous reset in the middle of a request
    do_reset("E");
    bus(1, 8'h90, 8'h07);
    step("E.push");
    bus(0, 8'h00, 8'h00);
    run_to_send("E", 40);
    RESET = 1'b0;
    model_reset();
    #1;
    chk("E.rst_send", SEND_PACKET, 0);
    chk("E.rst_cmd", COMMAND, 0);
    chk("E.rst_count", FIFO_COUNT, 0);
    @(negedge CLK);
    RESET = 1'b1;
    bus(1, 8'h90, 8'h08);
    step("E.push");
    bus(0, 8'h00, 8'h00);
    repeat (14) step("E.wait");
    chk("E.no_early_tick", SEND_PACKET, 0);
    step("E.tick");
    chk("E.tick16_send", SEND_PACKET, 1);
    chk("E.tick16_cmd", COMMAND, 4'h8);

    // Randomized traffic against the reference model
    do_reset("R");
    begin
      int busy_left = 0;
      int delay = 0;
      for (int c = 0; c < 600; c++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 35)      bus(1, 8'h90, 8'($urandom));
        else if (r < 38) bus(1, 8'h91, 8'($urandom));
        else if (r < 42) bus(1, 8'($urandom), 8'($urandom));
        else             bus(0, 8'h00, 8'h00);
        if (busy_left > 0) begin
          TX_BUSY = 1'b1;
          busy_left--;
        end else if (m_phase == 1) begin
          if (delay == 0) begin
            TX_BUSY = 1'b1;
            busy_left = $urandom_range(0, 20);
          end else begin
            TX_BUSY = 1'b0;
            delay--;
          end
        end else begin
          TX_BUSY = 1'b0;
          delay = $urandom_range(0, 3);
        end
        if (BUS_WE) $display("rnd %0d: write addr=%h data=%h", c, BUS_ADDR, BUS_DATA);
        step("R");
      end
    end
    bus(0, 8'h00, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
